ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 The module SHALL have parameter BURST_MAX, default 8, legal range 1..16: the maximum number of consecutive transfers one master may make while the other master is requesting.
REQ-002 The module SHALL have port clk, input, 1 bit: the clock; all state changes on its rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-004 The module SHALL have ports m0_req / m1_req, input, 1 bit each: the master requests access.
REQ-005 The module SHALL have ports m0_we / m1_we, input, 1 bit each: 1 selects a write transfer, 0 selects a read transfer.
REQ-006 The module SHALL have ports m0_addr / m1_addr, input, 8 bits each: the transfer address.
REQ-007 The module SHALL have ports m0_wdata / m1_wdata, input, 8 bits each: the write data.
REQ-008 The module SHALL have ports m0_gnt / m1_gnt, output, 1 bit each, registered: the master owns the RAM.
REQ-009 The module SHALL have ports m0_rvalid / m1_rvalid, output, 1 bit each, registered: read data is valid.
REQ-010 The module SHALL have ports m0_rdata / m1_rdata, output, 8 bits each, registered: the read data.
REQ-011 The module SHALL have ports ram_write_req, ram_r_addr, ram_w_addr, ram_w_data, outputs, 1/8/8/8 bits: they drive the single-port-write, async-read RAM.
REQ-012 The module SHALL have port ram_r_data, input, 8 bits: the asynchronous RAM read data.

Function
REQ-013 The module SHALL be in one of three states: IDLE, GNT0, GNT1. mX_gnt SHALL be 1 exactly when the state is GNTX.
REQ-014 A transfer SHALL occur in any cycle where mX_req=1 and mX_gnt=1; at most one transfer occurs per cycle.
REQ-015 For a write transfer, the module SHALL drive ram_write_req=1, ram_w_addr=mX_addr and ram_w_data=mX_wdata combinationally in the same cycle. The RAM updates at the closing edge.
REQ-016 For a read transfer, the module SHALL drive ram_r_addr=mX_addr combinationally. mX_rdata SHALL capture ram_r_data and mX_rvalid SHALL be 1 in the following cycle (latency 1). rvalid is a one-cycle pulse per read.
REQ-017 When no transfer occurs, ram_write_req SHALL be 0 and ram_r_addr, ram_w_addr and ram_w_data SHALL be 0. mX_rdata SHALL hold its last value.
REQ-018 From IDLE: with only mX_req=1, the next state SHALL be GNTX. With both requesting, the next state SHALL be the master other than last_served. With neither, the state SHALL stay IDLE. Grant latency is therefore 1 cycle.
REQ-019 From GNTX with mX_req=0: the next state SHALL be GNT(other) if the other master requests, else IDLE. The handover SHALL have no idle cycle.
REQ-020 A burst counter SHALL count transfers in the current grant and clear on every grant change.
REQ-021 From GNTX, if the counter reaches BURST_MAX on this cycle's transfer and the other master requests, the next state SHALL be GNT(other). If the other master is not requesting, GNTX SHALL continue and the counter SHALL saturate at BURST_MAX.
REQ-022 last_served SHALL update to X on every entry into GNTX.
REQ-023 A master SHALL hold we/addr/wdata stable only during cycles it issues a transfer. Dropping req while granted SHALL be legal and cause no transfer.
REQ-024 If rvalid is pending when the grant moves, the pending read SHALL still complete to the original master.

Reset
REQ-025 While reset=1, the module SHALL force state=IDLE, last_served=1 (so M0 wins the first tie), counter=0, mX_gnt=0, mX_rvalid=0 and mX_rdata=0. Since no transfer occurs, ram_write_req SHALL be 0.
REQ-026 A reset asserted mid-burst SHALL abort the burst at that edge. Any write in the reset cycle SHALL be suppressed, and no rvalid SHALL be issued for a read in the reset cycle.

Structure
REQ-027 Package ram_arb_pkg SHALL hold the state typedef (IDLE/GNT0/GNT1), the master-index constants M0=0 and M1=1, and the default BURST_MAX.
REQ-028 There SHALL be no sub-module. The arbiter is a single FSM plus datapath muxes. The RAM is instantiated outside, alongside it.

Verification
REQ-029 Single write: with reset released, m0 req/we=1, addr=0x10, wdata=0xA5. Required: m0_gnt=1 at the next edge, a RAM write of 0xA5 at 0x10 that cycle, and a later m1 read of 0x10 returning rdata=0xA5 with rvalid one cycle after the transfer.
REQ-030 Tie at IDLE after reset, both req=1: required m0 granted first. At the next tie after m0 releases, required m1 granted.
REQ-031 Burst limit, BURST_MAX=4, m0 requests continuously, m1 requests from cycle 2: required m0 gets exactly 4 transfers, then m1_gnt=1 on the following edge with no IDLE cycle. With m1 idle, m0 gets unlimited transfers.
REQ-032 Reads back-to-back: m0 reads 0x00..0x03 preloaded with 0x60, 0x80, 0xA0, 0x90. Required: rvalid high for 4 consecutive cycles with matching rdata, in order.
REQ-033 Reset mid-burst: reset=1 during an m1 write to 0x20 with data 0x33. Required: no write to 0x20, all gnt and rvalid 0 next cycle, and m0 wins the next tie.
REQ-034 Request drop: m0 granted drops req for 1 cycle while m1 is idle. Required: state returns to IDLE, ram_write_req=0 throughout, and re-grant 1 cycle after req returns.

Source files
------------

// File: rtl/ram_arb_pkg.sv
`default_nettype none
// ============================================================================
// ram_arb_pkg : arbiter state type, master indices and default burst limit
// Revision    : 1.0
// ============================================================================
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  localparam int BURST_MAX_DEFAULT = 8;

endpackage
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// ram_arbiter : two-master arbiter for a single-port-write, async-read RAM,
//               round-robin on ties with a per-grant burst limit
// Revision    : 1.0
// ============================================================================
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int BURST_MAX = BURST_MAX_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       m0_req,
  input  logic       m1_req,
  input  logic       m0_we,
  input  logic       m1_we,
  input  logic [7:0] m0_addr,
  input  logic [7:0] m1_addr,
  input  logic [7:0] m0_wdata,
  input  logic [7:0] m1_wdata,
  output logic       m0_gnt,
  output logic       m1_gnt,
  output logic       m0_rvalid,
  output logic       m1_rvalid,
  output logic [7:0] m0_rdata,
  output logic [7:0] m1_rdata,
  output logic       ram_write_req,
  output logic [7:0] ram_r_addr,
  output logic [7:0] ram_w_addr,
  output logic [7:0] ram_w_data,
  input  logic [7:0] ram_r_data
);

  localparam logic [4:0] c_burst_max = 5'(BURST_MAX);

  arb_state_t r_state;
  arb_state_t w_state_nxt;
  logic       r_last;
  logic [4:0] r_cnt;
  logic [4:0] w_cnt_nxt;
  logic       r_rvalid0;
  logic       r_rvalid1;
  logic [7:0] r_rdata0;
  logic [7:0] r_rdata1;

  logic       w_xfer0;
  logic       w_xfer1;
  logic       w_rd0;
  logic       w_rd1;
  logic       w_burst_done;
  logic       w_sel_we;
  logic [7:0] w_sel_addr;
  logic [7:0] w_sel_wdata;

  // Reset squashes the transfer so the reset cycle neither writes nor returns data
  assign w_xfer0 = m0_req && (r_state == GNT0) && !reset;
  assign w_xfer1 = m1_req && (r_state == GNT1) && !reset;
  assign w_rd0   = w_xfer0 && !m0_we;
  assign w_rd1   = w_xfer1 && !m1_we;

  assign w_sel_we    = w_xfer1 ? m1_we    : m0_we;
  assign w_sel_addr  = w_xfer1 ? m1_addr  : m0_addr;
  assign w_sel_wdata = w_xfer1 ? m1_wdata : m0_wdata;

  // True when this cycle's transfer uses up the owner's burst allowance
  assign w_burst_done = (r_cnt + 5'd1) >= c_burst_max;

  always_comb begin
    ram_write_req = 1'b0;
    ram_w_addr    = '0;
    ram_w_data    = '0;
    ram_r_addr    = '0;
    if (w_xfer0 || w_xfer1) begin
      if (w_sel_we) begin
        ram_write_req = 1'b1;
        ram_w_addr    = w_sel_addr;
        ram_w_data    = w_sel_wdata;
      end else begin
        ram_r_addr = w_sel_addr;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (m0_req && m1_req) w_state_nxt = (r_last == M1) ? GNT0 : GNT1;
        else if (m0_req)      w_state_nxt = GNT0;
        else if (m1_req)      w_state_nxt = GNT1;
      end
      GNT0: begin
        if (!m0_req)                      w_state_nxt = m1_req ? GNT1 : IDLE;
        else if (w_burst_done && m1_req)  w_state_nxt = GNT1;
      end
      GNT1: begin
        if (!m1_req)                      w_state_nxt = m0_req ? GNT0 : IDLE;
        else if (w_burst_done && m0_req)  w_state_nxt = GNT0;
      end
      default: w_state_nxt = IDLE;
    endcase

    w_cnt_nxt = r_cnt;
    if (w_state_nxt != r_state)
      w_cnt_nxt = '0;
    else if ((w_xfer0 || w_xfer1) && (r_cnt < c_burst_max))
      w_cnt_nxt = r_cnt + 5'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_last    <= M1;
      r_cnt     <= '0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_rdata0  <= '0;
      r_rdata1  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      if (w_state_nxt == GNT0 && r_state != GNT0) r_last <= M0;
      if (w_state_nxt == GNT1 && r_state != GNT1) r_last <= M1;
      // Read returns are steered by who issued them, not by the current grant
      r_rvalid0 <= w_rd0;
      r_rvalid1 <= w_rd1;
      if (w_rd0) r_rdata0 <= ram_r_data;
      if (w_rd1) r_rdata1 <= ram_r_data;
    end
  end

  assign m0_gnt    = (r_state == GNT0);
  assign m1_gnt    = (r_state == GNT1);
  assign m0_rvalid = r_rvalid0;
  assign m1_rvalid = r_rvalid1;
  assign m0_rdata  = r_rdata0;
  assign m1_rdata  = r_rdata1;

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// tb_ram_arbiter : directed and randomized checks of ram_arbiter with a
//                  behavioural RAM and a transaction-level reference model
// Revision       : 1.0
// ============================================================================
module tb_ram_arbiter;

  localparam int BURST = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] req;
  logic [1:0] we;
  logic [7:0] addr  [2];
  logic [7:0] wdata [2];
  logic       m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [7:0] m0_rdata, m1_rdata;
  logic       ram_write_req;
  logic [7:0] ram_r_addr, ram_w_addr, ram_w_data, ram_r_data;

  logic [7:0] ram [256];
  logic       pre_we;
  logic [7:0] pre_addr, pre_data;

  int         mdl_owner;
  int         mdl_cnt;
  int         mdl_last;
  logic [1:0] mdl_rv;
  logic [7:0] mdl_rd  [2];
  logic [7:0] mdl_mem [256];

  int pass_cnt = 0;
  int chk_cnt  = 0;

  ram_arbiter #(.BURST_MAX(BURST)) dut (
    .clk(clk), .reset(reset),
    .m0_req(req[0]), .m1_req(req[1]), .m0_we(we[0]), .m1_we(we[1]),
    .m0_addr(addr[0]), .m1_addr(addr[1]), .m0_wdata(wdata[0]), .m1_wdata(wdata[1]),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .ram_write_req(ram_write_req), .ram_r_addr(ram_r_addr), .ram_w_addr(ram_w_addr),
    .ram_w_data(ram_w_data), .ram_r_data(ram_r_data)
  );

  always #5 clk = ~clk;

  // External RAM: synchronous write, asynchronous read, plus a bench preload port
  always @(posedge clk) begin
    if (ram_write_req) ram[ram_w_addr] <= ram_w_data;
    else if (pre_we)   ram[pre_addr]   <= pre_data;
  end
  assign ram_r_data = ram[ram_r_addr];

  // Transaction-level view of one clock edge: who transfers, what memory and
  // read returns result, and who owns the RAM afterwards.
  function automatic void model_update();
    int   win, oth, used;
    logic xfer;
    if (reset) begin
      mdl_owner = -1; mdl_cnt = 0; mdl_last = 1; mdl_rv = 2'b00;
      mdl_rd[0] = 8'h00; mdl_rd[1] = 8'h00;
      return;
    end
    xfer   = (mdl_owner >= 0) && req[mdl_owner];
    mdl_rv = 2'b00;
    if (xfer) begin
      if (we[mdl_owner]) mdl_mem[addr[mdl_owner]] = wdata[mdl_owner];
      else begin
        mdl_rv[mdl_owner] = 1'b1;
        mdl_rd[mdl_owner] = mdl_mem[addr[mdl_owner]];
      end
    end
    if (mdl_owner < 0) begin
      if (req == 2'b11)   win = 1 - mdl_last;
      else if (req[0])    win = 0;
      else if (req[1])    win = 1;
      else                win = -1;
    end else begin
      oth = 1 - mdl_owner;
      if (!req[mdl_owner]) win = req[oth] ? oth : -1;
      else begin
        used = mdl_cnt + 1;
        win  = (used >= BURST && req[oth]) ? oth : mdl_owner;
      end
    end
    if (win != mdl_owner) begin
      mdl_cnt = 0;
      if (win >= 0) mdl_last = win;
    end else if (xfer && mdl_cnt < BURST) begin
      mdl_cnt = mdl_cnt + 1;
    end
    mdl_owner = win;
  endfunction

  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d; mdl_mem[a] = d;
    tick();
    pre_we = 1'b0;
  endtask

  task automatic do_reset();
    req = 2'b00; reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 2'b11; we = 2'b11;
    addr[0] = 8'h05; addr[1] = 8'h06; wdata[0] = 8'h77; wdata[1] = 8'h88;
    #1;
    chk_cnt++;
    if (ram_write_req !== 1'b0) $display("FAIL reset_wreq: got %b expected 0", ram_write_req);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if ({m1_gnt, m0_gnt} !== 2'b00) $display("FAIL reset_gnt: got %b expected 00", {m1_gnt, m0_gnt});
    else pass_cnt++;
    chk_cnt++;
    if ({m1_rvalid, m0_rvalid} !== 2'b00) $display("FAIL reset_rvalid: got %b expected 00", {m1_rvalid, m0_rvalid});
    else pass_cnt++;
    chk_cnt++;
    if ({m1_rdata, m0_rdata} !== 16'h0000) $display("FAIL reset_rdata: got %h expected 0000", {m1_rdata, m0_rdata});
    else pass_cnt++;
    req = 2'b00; we = 2'b00; reset = 1'b0;
  endtask

  task automatic test_single_write();
    do_reset();
    req = 2'b01; we = 2'b01; addr[0] = 8'h10; wdata[0] = 8'hA5;
    tick();
    chk_cnt++;
    if (m0_gnt !== 1'b1) $display("FAIL sw_gnt: got %b expected 1", m0_gnt);
    else pass_cnt++;
    chk_cnt++;
    if ({ram_write_req, ram_w_addr, ram_w_data} !== {1'b1, 8'h10, 8'hA5})
      $display("FAIL sw_ram: got %b/%h/%h expected 1/10/a5", ram_write_req, ram_w_addr, ram_w_data);
    else pass_cnt++;
    tick();
    req = 2'b10; we = 2'b00; addr[1] = 8'h10;
    tick();
    chk_cnt++;
    if ({m1_gnt, ram_r_addr} !== {1'b1, 8'h10}) $display("FAIL sw_rd_issue: got %b/%h expected 1/10", m1_gnt, ram_r_addr);
    else pass_cnt++;
    tick();
    req = 2'b00;
    chk_cnt++;
    if ({m1_rvalid, m1_rdata} !== {1'b1, 8'hA5}) $display("FAIL sw_rd_data: got %b/%h expected 1/a5", m1_rvalid, m1_rdata);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (m1_rvalid !== 1'b0) $display("FAIL sw_rv_pulse: got %b expected 0", m1_rvalid);
    else pass_cnt++;
  endtask

  task automatic test_tie();
    do_reset();
    req = 2'b11; we = 2'b00; addr[0] = 8'h01; addr[1] = 8'h02;
    tick();
    chk_cnt++;
    if ({m1_gnt, m0_gnt} !== 2'b01) $display("FAIL tie_first: got %b expected 01", {m1_gnt, m0_gnt});
    else pass_cnt++;
    req = 2'b00;
    tick();
    chk_cnt++;
    if ({m1_gnt, m0_gnt} !== 2'b00) $display("FAIL tie_idle: got %b expected 00", {m1_gnt, m0_gnt});
    else pass_cnt++;
    req = 2'b11;
    tick();
    chk_cnt++;
    if ({m1_gnt, m0_gnt} !== 2'b10) $display("FAIL tie_second: got %b expected 10", {m1_gnt, m0_gnt});
    else pass_cnt++;
    req = 2'b00;
    tick();
  endtask

  task automatic test_burst();
    int n0, last_m0, first_m1;
    do_reset();
    req = 2'b01; we = 2'b11; n0 = 0; last_m0 = -1; first_m1 = -1;
    for (int c = 0; c < 12; c++) begin
      if (c == 2) req[1] = 1'b1;
      addr[0] = 8'(c + 8'h80); wdata[0] = 8'(c); addr[1] = 8'(c + 8'h90); wdata[1] = 8'(c);
      if (first_m1 < 0 && m1_gnt) first_m1 = c;
      if (first_m1 < 0 && m0_gnt) begin n0++; last_m0 = c; end
      tick();
    end
    chk_cnt++;
    if (n0 !== BURST) $display("FAIL burst_count: got %0d expected %0d", n0, BURST);
    else pass_cnt++;
    chk_cnt++;
    if (first_m1 !== last_m0 + 1) $display("FAIL burst_handover: got m1 at %0d expected %0d", first_m1, last_m0 + 1);
    else pass_cnt++;
    do_reset();
    req = 2'b01;
    tick();
    n0 = 0;
    for (int c = 0; c < 20; c++) begin
      if (m0_gnt) n0++;
      tick();
    end
    chk_cnt++;
    if (n0 !== 20) $display("FAIL burst_unlimited: got %0d expected 20", n0);
    else pass_cnt++;
    req = 2'b00;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [4];
    exp[0] = 8'h60; exp[1] = 8'h80; exp[2] = 8'hA0; exp[3] = 8'h90;
    req = 2'b00; reset = 1'b1;
    for (int i = 0; i < 4; i++) preload(8'(i), exp[i]);
    reset = 1'b0;
    req = 2'b01; we = 2'b00; addr[0] = 8'h00;
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_cnt++;
      if ({m0_rvalid, m0_rdata} !== {1'b1, exp[i]})
        $display("FAIL b2b_read%0d: got %b/%h expected 1/%h", i, m0_rvalid, m0_rdata, exp[i]);
      else pass_cnt++;
      if (i < 3) addr[0] = 8'(i + 1);
      else req = 2'b00;
    end
    tick();
  endtask

  task automatic test_reset_mid_burst();
    req = 2'b00; reset = 1'b1;
    preload(8'h20, 8'hEE);
    reset = 1'b0;
    req = 2'b10; we = 2'b10; addr[1] = 8'h40; wdata[1] = 8'h11;
    tick();
    tick();
    addr[1] = 8'h20; wdata[1] = 8'h33; reset = 1'b1;
    #1;
    chk_cnt++;
    if (ram_write_req !== 1'b0) $display("FAIL rmb_wreq: got %b expected 0", ram_write_req);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if ({m1_gnt, m0_gnt, m1_rvalid, m0_rvalid} !== 4'b0000)
      $display("FAIL rmb_outputs: got %b expected 0000", {m1_gnt, m0_gnt, m1_rvalid, m0_rvalid});
    else pass_cnt++;
    chk_cnt++;
    if (ram[8'h20] !== 8'hEE) $display("FAIL rmb_mem: got %h expected ee", ram[8'h20]);
    else pass_cnt++;
    reset = 1'b0; req = 2'b11; we = 2'b00;
    tick();
    chk_cnt++;
    if ({m1_gnt, m0_gnt} !== 2'b01) $display("FAIL rmb_tie: got %b expected 01", {m1_gnt, m0_gnt});
    else pass_cnt++;
    req = 2'b00;
    tick();
  endtask

  task automatic test_req_drop();
    do_reset();
    req = 2'b01; we = 2'b01; addr[0] = 8'h55; wdata[0] = 8'h5A;
    tick();
    tick();
    req = 2'b00;
    #1;
    chk_cnt++;
    if (ram_write_req !== 1'b0) $display("FAIL drop_wreq_gnt: got %b expected 0", ram_write_req);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (m0_gnt !== 1'b0) $display("FAIL drop_idle: got %b expected 0", m0_gnt);
    else pass_cnt++;
    req = 2'b01;
    #1;
    chk_cnt++;
    if (ram_write_req !== 1'b0) $display("FAIL drop_wreq_idle: got %b expected 0", ram_write_req);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (m0_gnt !== 1'b1) $display("FAIL drop_regrant: got %b expected 1", m0_gnt);
    else pass_cnt++;
    req = 2'b00;
    tick();
  endtask

  task automatic test_random();
    logic       x;
    logic [7:0] xa, xd;
    logic       xw;
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 49) == 0);
      req   = 2'($urandom);
      we    = 2'($urandom);
      for (int m = 0; m < 2; m++) begin
        addr[m]  = 8'($urandom_range(0, 15));
        wdata[m] = 8'($urandom);
      end
      #1;
      x  = !reset && (mdl_owner >= 0) && req[mdl_owner];
      xw = x && we[mdl_owner];
      xa = x ? addr[mdl_owner] : 8'h00;
      xd = x ? wdata[mdl_owner] : 8'h00;
      chk_cnt++;
      if ({ram_write_req, ram_w_addr, ram_w_data, ram_r_addr} !==
          {xw, xw ? xa : 8'h00, xw ? xd : 8'h00, (x && !xw) ? xa : 8'h00})
        $display("FAIL rnd_ram cyc%0d: got %b/%h/%h/%h expected %b/%h/%h/%h", n,
                 ram_write_req, ram_w_addr, ram_w_data, ram_r_addr,
                 xw, xw ? xa : 8'h00, xw ? xd : 8'h00, (x && !xw) ? xa : 8'h00);
      else pass_cnt++;
      tick();
      chk_cnt++;
      if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata} !==
          {mdl_owner == 0, mdl_owner == 1, mdl_rv[0], mdl_rv[1], mdl_rd[0], mdl_rd[1]})
        $display("FAIL rnd_out cyc%0d: got g%b%b v%b%b d%h/%h expected g%b%b v%b%b d%h/%h", n,
                 m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
                 mdl_owner == 0, mdl_owner == 1, mdl_rv[0], mdl_rv[1], mdl_rd[0], mdl_rd[1]);
      else pass_cnt++;
    end
    reset = 1'b0; req = 2'b00;
    tick();
  endtask

  initial begin
    reset = 1'b1; req = 2'b00; we = 2'b00; pre_we = 1'b0; pre_addr = 8'h00; pre_data = 8'h00;
    addr[0] = 8'h00; addr[1] = 8'h00; wdata[0] = 8'h00; wdata[1] = 8'h00;
    mdl_owner = -1; mdl_cnt = 0; mdl_last = 1; mdl_rv = 2'b00; mdl_rd[0] = 8'h00; mdl_rd[1] = 8'h00;
    for (int a = 0; a < 256; a++) preload(8'(a), 8'h00);
    test_reset();
    test_single_write();
    test_tie();
    test_burst();
    test_back_to_back();
    test_reset_mid_burst();
    test_req_drop();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
`default_nettype wire
